// File: rtl/sipo_deser_if.sv
// Bus bundle for sipo_deser: serial input side, clear, and the parallel
// word handshake. Master drives the stimulus, slave is the deserializer.
interface sipo_deser_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic             clear;
  logic             shift_en;
  logic             bit_in;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             overrun;
  logic [CW-1:0]    bit_cnt;

  modport master (
    output clear, shift_en, bit_in, out_ready,
    input  data_out, out_valid, overrun, bit_cnt
  );

  modport slave (
    input  clear, shift_en, bit_in, out_ready,
    output data_out, out_valid, overrun, bit_cnt
  );
endinterface

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer with frame bit counter, selectable bit order,
// holding register with valid/ready handshake and sticky overrun flag.
module sipo_deser #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  sipo_deser_if.slave bus
);

  localparam int unsigned CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < 4) begin : g_width_check
    $error("sipo_deser: WIDTH must be >= 4");
  end

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             valid_q, valid_d;
  logic             ovr_q,   ovr_d;

  logic [WIDTH-1:0] shreg_nxt_c;
  logic             complete_c;
  logic             consume_c;

  // Shift direction is fixed at elaboration time.
  if (LSB_FIRST) begin : g_lsb_first
    assign shreg_nxt_c = {bus.bit_in, shreg_q[WIDTH-1:1]};
  end else begin : g_msb_first
    assign shreg_nxt_c = {shreg_q[WIDTH-2:0], bus.bit_in};
  end

  assign complete_c = bus.shift_en && (cnt_q == LAST);
  assign consume_c  = valid_q && bus.out_ready;

  // Next-state logic; clear outranks shifting and the handshake.
  always_comb begin
    shreg_d = shreg_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (bus.clear) begin
      shreg_d = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      if (bus.shift_en) begin
        shreg_d = shreg_nxt_c;
        cnt_d   = complete_c ? '0 : cnt_q + CW'(1);
      end

      if (complete_c) begin
        // A completed word is accepted only if the holding register is free
        // or is being drained at this very edge; otherwise it is dropped.
        if (!valid_q || consume_c) begin
          data_d  = shreg_nxt_c;
          valid_d = 1'b1;
        end else begin
          ovr_d   = 1'b1;
        end
      end else if (consume_c) begin
        valid_d = 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.overrun   = ovr_q;
  assign bus.bit_cnt   = cnt_q;

endmodule
